// File: rtl/eth_fcs_check_pkg.sv
// Shared Ethernet receive constants and the FCS checker state encoding.
package eth_fcs_check_pkg;
  localparam int          BYTE_LEN      = 8;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_FCS_LEN   = 4;
  localparam int          ETH_MIN_FRAME = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } fcs_state_e;
endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step over one byte, LSB first.
// Shared with the transmit path for FCS generation.
module crc32_byte
  import eth_fcs_check_pkg::*;
(
  input  logic [31:0]         i_crc,
  input  logic [BYTE_LEN-1:0] i_byte,
  output logic [31:0]         o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {{(32-BYTE_LEN){1'b0}}, i_byte};
    for (int i = 0; i < BYTE_LEN; i++)
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
    o_crc = w_c;
  end

endmodule

// File: rtl/eth_fcs_check.sv
// Receive-side FCS checker: CRC-32 over the whole frame, strips the trailing
// 4-byte FCS via a delay line, and reports length/CRC/runt status at frame end.
module eth_fcs_check
  import eth_fcs_check_pkg::*;
#(
  parameter int LEN_W     = 11,
  parameter int MIN_FRAME = ETH_MIN_FRAME
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inclk,
  input  logic [BYTE_LEN-1:0] in,
  input  logic                in_done,
  output logic                outclk,
  output logic [BYTE_LEN-1:0] out,
  output logic                done,
  output logic                crc_ok,
  output logic                runt,
  output logic [LEN_W-1:0]    len
);

  localparam int CNT_W = $clog2(MIN_FRAME + 1);

  fcs_state_e                             r_state, w_state_nxt;
  logic [2:0]                             r_fill, w_fill_nxt;
  logic [ETH_FCS_LEN-1:0][BYTE_LEN-1:0]   r_dly;
  logic [31:0]                            r_crc, w_crc_upd, w_crc_nxt;
  logic [CNT_W-1:0]                       r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]                       r_len, w_len_nxt;
  logic                                   w_emit;

  crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (in),
    .o_crc  (w_crc_upd)
  );

  // Next-state values include the byte arriving this cycle, so an inclk
  // coinciding with in_done is counted before the status is latched.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_emit      = 1'b0;
    if (inclk) begin
      w_crc_nxt = w_crc_upd;
      if (r_cnt != CNT_W'(MIN_FRAME))
        w_cnt_nxt = r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          w_fill_nxt  = 3'd1;
          w_len_nxt   = '0;
          w_state_nxt = S_FILL;
        end
        S_FILL: begin
          w_fill_nxt = r_fill + 3'd1;
          if (r_fill == 3'd3)
            w_state_nxt = S_STREAM;
        end
        default: begin
          w_emit = 1'b1;
          if (r_len != '1)
            w_len_nxt = r_len + LEN_W'(1);
        end
      endcase
    end else if (in_done && r_state == S_IDLE) begin
      w_len_nxt = '0;
    end
    if (in_done)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
      r_dly  <= '0;
      r_crc  <= CRC32_INIT;
      r_cnt  <= '0;
      r_len  <= '0;
      outclk <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
      crc_ok <= 1'b0;
      runt   <= 1'b0;
    end else begin
      outclk <= w_emit;
      if (w_emit)
        out <= r_dly[ETH_FCS_LEN-1];
      done  <= in_done;
      r_len <= w_len_nxt;
      if (in_done) begin
        crc_ok <= (w_fill_nxt == 3'd4) && (w_crc_nxt == CRC32_RESIDUE);
        runt   <= (w_cnt_nxt < CNT_W'(MIN_FRAME));
        r_fill <= '0;
        r_dly  <= '0;
        r_crc  <= CRC32_INIT;
        r_cnt  <= '0;
      end else begin
        r_fill <= w_fill_nxt;
        r_crc  <= w_crc_nxt;
        r_cnt  <= w_cnt_nxt;
        if (inclk)
          r_dly <= {r_dly[ETH_FCS_LEN-2:0], in};
      end
    end
  end

  assign len = r_len;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check: known-answer frames, runts, back-to-back
// and sparse input, in_done coinciding with the last byte, and mid-frame reset.
module tb_eth_fcs_check;

  logic        clk = 1'b0;
  logic        rst, inclk, in_done;
  logic [7:0]  in;
  logic        outclk, done, crc_ok, runt;
  logic [7:0]  out;
  logic [10:0] len;

  int ncmp = 0;
  int nerr = 0;

  eth_fcs_check dut (
    .clk(clk), .rst(rst), .inclk(inclk), .in(in), .in_done(in_done),
    .outclk(outclk), .out(out), .done(done), .crc_ok(crc_ok),
    .runt(runt), .len(len)
  );

  always #10 clk = ~clk;

  // Monitor: collect emitted bytes and close a record on each done.
  logic [7:0]  outq[$];
  logic [7:0]  rec_bytes[$];
  int          rec_nout[$];
  logic        rec_ok[$], rec_runt[$];
  logic [10:0] rec_len[$];
  int          ndone = 0, cur_run = 0, max_run = 0;

  always @(negedge clk) begin
    if (outclk === 1'b1) begin
      outq.push_back(out);
      cur_run = cur_run + 1;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (done === 1'b1) begin
      ndone = ndone + 1;
      rec_nout.push_back(outq.size());
      while (outq.size() > 0) rec_bytes.push_back(outq.pop_front());
      rec_ok.push_back(crc_ok);
      rec_runt.push_back(runt);
      rec_len.push_back(len);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ q[k][i];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  // Drive a frame; ends #1 after the edge that registers done.
  task automatic run_frame(input logic [7:0] q[$], input int gap, input bit merge);
    foreach (q[k]) begin
      inclk   = 1'b1;
      in      = q[k];
      in_done = merge && (k == q.size() - 1);
      @(posedge clk); #1;
      inclk = 1'b0; in_done = 1'b0;
      if (k != q.size() - 1)
        repeat (gap - 1) begin @(posedge clk); #1; end
    end
    if (!merge) begin
      in_done = 1'b1;
      @(posedge clk); #1;
      in_done = 1'b0;
    end
    chk("done_latency", {31'd0, done}, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp[$],
                              input logic ok, input logic rn, input int ln);
    int n, guard;
    guard = 0;
    while (rec_nout.size() == 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    if (rec_nout.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    n = rec_nout.pop_front();
    chk({tag, "_nout"}, n, exp.size());
    for (int i = 0; i < n; i++) begin
      if (i < exp.size()) chk({tag, "_byte"}, {24'd0, rec_bytes[0]}, {24'd0, exp[i]});
      void'(rec_bytes.pop_front());
    end
    chk({tag, "_crc_ok"}, {31'd0, rec_ok.pop_front()}, {31'd0, ok});
    chk({tag, "_runt"},   {31'd0, rec_runt.pop_front()}, {31'd0, rn});
    chk({tag, "_len"},    {21'd0, rec_len.pop_front()}, ln);
  endtask

  initial begin
    logic [7:0] f_good[$], p_good[$], f_bad[$], p_bad[$], f60[$], p60[$], f3[$], none[$];
    logic [31:0] fcs;
    int d0;

    f_good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    p_good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f_bad = f_good;  f_bad[4] = 8'h34;
    p_bad = p_good;  p_bad[4] = 8'h34;
    for (int i = 0; i < 60; i++) p60.push_back(8'((i * 37 + 5) ^ (i >> 2)));
    fcs = ~ref_crc(p60);
    f60 = p60;
    for (int i = 0; i < 4; i++) f60.push_back(fcs[8*i +: 8]);
    f3 = '{8'hAA, 8'hBB, 8'hCC};

    rst = 1'b1; inclk = 1'b0; in_done = 1'b0; in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outclk", {31'd0, outclk}, 32'd0);
    chk("rst_out",    {24'd0, out},    32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("rst_runt",   {31'd0, runt},   32'd0);
    chk("rst_len",    {21'd0, len},    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(f_good, 1, 0);  expect_frame("good9", p_good, 1'b1, 1'b1, 9);
    repeat (2) @(posedge clk); #1;
    run_frame(f_bad, 1, 0);   expect_frame("bad9", p_bad, 1'b0, 1'b1, 9);
    repeat (2) @(posedge clk); #1;

    max_run = 0;
    run_frame(f60, 1, 0);     expect_frame("f60_b2b", p60, 1'b1, 1'b0, 60);
    chk("f60_b2b_run", max_run, 60);
    repeat (2) @(posedge clk); #1;
    max_run = 0;
    run_frame(f60, 4, 0);     expect_frame("f60_gap4", p60, 1'b1, 1'b0, 60);
    chk("f60_gap4_run", max_run, 1);
    repeat (2) @(posedge clk); #1;

    run_frame(f3, 1, 0);      expect_frame("short3", none, 1'b0, 1'b1, 0);
    repeat (2) @(posedge clk); #1;
    run_frame(none, 1, 0);    expect_frame("empty", none, 1'b0, 1'b1, 0);
    repeat (2) @(posedge clk); #1;

    // Last byte with in_done, then the next frame starts in the done cycle.
    run_frame(f_good, 1, 1);
    run_frame(f_good, 1, 0);
    expect_frame("merge1", p_good, 1'b1, 1'b1, 9);
    expect_frame("merge2", p_good, 1'b1, 1'b1, 9);
    repeat (2) @(posedge clk); #1;

    // Abort a frame by reset after 20 bytes.
    d0 = ndone;
    for (int k = 0; k < 20; k++) begin
      inclk = 1'b1; in = f60[k];
      @(posedge clk); #1;
    end
    inclk = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outclk", {31'd0, outclk}, 32'd0);
    chk("abort_len",    {21'd0, len},    32'd0);
    outq.delete();
    repeat (10) @(posedge clk); #1;
    chk("abort_no_done", ndone - d0, 0);
    run_frame(f_good, 1, 0);  expect_frame("after_rst", p_good, 1'b1, 1'b1, 9);
    chk("after_rst_ndone", ndone - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
